// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Multi-ported integer register file with a per-register
//               scoreboard (busy bits). Two combinational read ports, one
//               write-back port that writes data and clears the busy bit, and
//               one allocation port that reserves a destination register.
//               Register 0 is hard-wired to zero and can never become busy.
// Revision    : 1.0 - initial release
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN - a read that hits the register being written back in
//                       the same cycle returns the incoming write data, and
//                       its busy bit reads 0. Without it, the read returns
//                       the stored value and the stored busy bit.
//
// Parameters:
//   XLEN  register width in bits
//   NREG  register count (power of two, 2..64); AW = log2(NREG)
//
// Ports:
//   clk          in   1      clock, rising-edge active
//   rst          in   1      asynchronous active-high reset
//   ra1, ra2     in   AW     read addresses
//   rd1, rd2     out  XLEN   read data (combinational)
//   rbusy1/2     out  1      busy bit of ra1/ra2 (combinational)
//   we           in   1      write-back enable
//   wa           in   AW     write-back address
//   wd           in   XLEN   write-back data
//   alloc_en     in   1      reserve a destination register
//   alloc_addr   in   AW     register to reserve
//   alloc_ok     out  1      reservation accepted this cycle (combinational)
//   flush        in   1      clear every busy bit (pipeline squash)
//   busy_cnt     out  AW+1   registered number of busy registers
// ============================================================================
module reg_file_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rbusy1,
  output logic            rbusy2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_addr,
  output logic            alloc_ok,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);

  // Storage and scoreboard state
  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     busy_cnt_q;
  logic [AW:0]     busy_cnt_d;

  // Per-cycle helpers
  logic            wb_act;      // write-back to a real (non-zero) register
  logic [NREG-1:0] wb_mask;     // one-hot of the register being written back
  logic [NREG-1:0] busy_eff;    // busy bits with this cycle's write-back applied
  logic [NREG-1:0] alloc_mask;  // one-hot of an accepted reservation

  // --------------------------------------------------------------------------
  // Scoreboard next state
  // --------------------------------------------------------------------------
  always_comb begin
    wb_act   = we & (wa != '0);
    wb_mask  = wb_act ? (NREG'(1) << wa) : '0;
    // A register being written back this cycle is free for a new reservation,
    // so the allocation check looks at busy bits with that clear applied.
    busy_eff = busy_q & ~wb_mask;

    alloc_ok = alloc_en & (alloc_addr != '0) & ~busy_eff[alloc_addr]
             & ~flush & ~rst;
    alloc_mask = alloc_ok ? (NREG'(1) << alloc_addr) : '0;

    // Clear-then-set ordering: a same-edge write-back and reservation of the
    // same register leaves it busy for the new producer.
    busy_d    = flush ? '0 : (busy_eff | alloc_mask);
    busy_d[0] = 1'b0;

    busy_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
    end
  end

  // --------------------------------------------------------------------------
  // Read port 1
  // --------------------------------------------------------------------------
  always_comb begin
    rd1    = '0;
    rbusy1 = 1'b0;
    if (!rst && (ra1 != '0)) begin
      rd1    = regs_q[ra1];
      rbusy1 = busy_q[ra1];
`ifdef REGFILE_BYPASS_EN
      if (wb_act && (wa == ra1)) begin
        rd1    = wd;
        rbusy1 = 1'b0;
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Read port 2
  // --------------------------------------------------------------------------
  always_comb begin
    rd2    = '0;
    rbusy2 = 1'b0;
    if (!rst && (ra2 != '0)) begin
      rd2    = regs_q[ra2];
      rbusy2 = busy_q[ra2];
`ifdef REGFILE_BYPASS_EN
      if (wb_act && (wa == ra2)) begin
        rd2    = wd;
        rbusy2 = 1'b0;
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      // Flush only squashes reservations; the write-back data still lands.
      if (wb_act) begin
        regs_q[wa] <= wd;
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Self-checking bench for reg_file_sb. Directed scenarios plus a
//               randomized run compared against an array-based reference
//               model of the register file and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   ra1, ra2;
  logic [XLEN-1:0] rd1, rd2;
  logic            rbusy1, rbusy2;
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic            alloc_ok;
  logic            flush;
  logic [AW:0]     busy_cnt;

  int n_checks;
  int n_errors;

  // Reference model
  logic [XLEN-1:0] m_mem  [NREG];
  bit              m_busy [NREG];

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk        (clk),
    .rst        (rst),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .rbusy1     (rbusy1),
    .rbusy2     (rbusy2),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_ok   (alloc_ok),
    .flush      (flush),
    .busy_cnt   (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 0 && wa == a) return wd;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_rbusy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 0 && wa == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic logic exp_alloc_ok();
    bit still_busy;
    still_busy = m_busy[alloc_addr] && !(we && wa == alloc_addr);
    return alloc_en && (alloc_addr != 0) && !flush && !still_busy;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0; alloc_en = 0; alloc_addr = 0; flush = 0;
  endtask

  // Advance one clock, updating the model with the inputs present at the edge.
  task automatic step();
    bit ok;
    ok = exp_alloc_ok();
    if (we && wa != 0) begin
      m_mem[wa]  = wd;
      m_busy[wa] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else if (ok) begin
      m_busy[alloc_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst = 1'b1;
    // Writes and allocs presented during reset must be ignored.
    we = 1; wa = 3; wd = 64'hFFFF_0000_FFFF_0000; alloc_en = 1; alloc_addr = 3;
    ra1 = 3; ra2 = 3;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rd1 !== '0) begin n_errors++; $display("FAIL rst_rd1: got %h expected 0", rd1); end
    n_checks++;
    if (alloc_ok !== 1'b0) begin n_errors++; $display("FAIL rst_alloc_ok: got %b expected 0", alloc_ok); end
    n_checks++;
    if (rbusy2 !== 1'b0) begin n_errors++; $display("FAIL rst_rbusy2: got %b expected 0", rbusy2); end
    n_checks++;
    if (busy_cnt !== '0) begin n_errors++; $display("FAIL rst_busy_cnt: got %0d expected 0", busy_cnt); end
    idle();
    rst = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < NREG; i++) begin
      ra1 = AW'(i);
      ra2 = AW'(NREG - 1 - i);
      #1;
      n_checks++;
      if (rd1 !== '0 || rd2 !== '0) begin
        n_errors++; $display("FAIL post_rst_rd[%0d]: got %h/%h expected 0/0", i, rd1, rd2);
      end
      n_checks++;
      if (rbusy1 !== 1'b0 || rbusy2 !== 1'b0) begin
        n_errors++; $display("FAIL post_rst_rbusy[%0d]: got %b/%b expected 0/0", i, rbusy1, rbusy2);
      end
    end
    n_checks++;
    if (busy_cnt !== '0) begin n_errors++; $display("FAIL post_rst_busy_cnt: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_double_alloc();
    do_reset();
    alloc_en = 1; alloc_addr = 5;
    #1;
    n_checks++;
    if (alloc_ok !== 1'b1) begin n_errors++; $display("FAIL dalloc_ok1: got %b expected 1", alloc_ok); end
    step();
    n_checks++;
    if (busy_cnt !== 6'd1) begin n_errors++; $display("FAIL dalloc_cnt1: got %0d expected 1", busy_cnt); end
    n_checks++;
    if (alloc_ok !== 1'b0) begin n_errors++; $display("FAIL dalloc_ok2: got %b expected 0", alloc_ok); end
    step();
    n_checks++;
    if (busy_cnt !== 6'd1) begin n_errors++; $display("FAIL dalloc_cnt2: got %0d expected 1", busy_cnt); end
    idle();
  endtask

  task automatic test_wb_alloc_same();
    do_reset();
    alloc_en = 1; alloc_addr = 5;
    step();
    we = 1; wa = 5; wd = 64'h0000_0000_DEAD_BEEF;
    #1;
    n_checks++;
    if (alloc_ok !== 1'b1) begin n_errors++; $display("FAIL wbsame_ok: got %b expected 1", alloc_ok); end
    step();
    idle();
    ra1 = 5;
    #1;
    n_checks++;
    if (rd1 !== 64'h0000_0000_DEAD_BEEF) begin n_errors++; $display("FAIL wbsame_rd: got %h expected deadbeef", rd1); end
    n_checks++;
    if (rbusy1 !== 1'b1) begin n_errors++; $display("FAIL wbsame_busy: got %b expected 1", rbusy1); end
    n_checks++;
    if (busy_cnt !== 6'd1) begin n_errors++; $display("FAIL wbsame_cnt: got %0d expected 1", busy_cnt); end
  endtask

  task automatic test_x0();
    do_reset();
    we = 1; wa = 0; wd = '1; alloc_en = 1; alloc_addr = 0;
    #1;
    n_checks++;
    if (alloc_ok !== 1'b0) begin n_errors++; $display("FAIL x0_alloc_ok: got %b expected 0", alloc_ok); end
    step();
    idle();
    ra1 = 0; ra2 = 0;
    #1;
    n_checks++;
    if (rd1 !== '0 || rbusy1 !== 1'b0) begin n_errors++; $display("FAIL x0_rd: got %h/%b expected 0/0", rd1, rbusy1); end
    n_checks++;
    if (busy_cnt !== '0) begin n_errors++; $display("FAIL x0_cnt: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      alloc_en = 1; alloc_addr = AW'(i);
      step();
    end
    n_checks++;
    if (busy_cnt !== 6'd3) begin n_errors++; $display("FAIL flush_pre_cnt: got %0d expected 3", busy_cnt); end
    flush = 1; we = 1; wa = 2; wd = 64'd7; alloc_en = 1; alloc_addr = 4;
    #1;
    n_checks++;
    if (alloc_ok !== 1'b0) begin n_errors++; $display("FAIL flush_alloc_ok: got %b expected 0", alloc_ok); end
    step();
    idle();
    ra1 = 2; ra2 = 4;
    #1;
    n_checks++;
    if (busy_cnt !== '0) begin n_errors++; $display("FAIL flush_cnt: got %0d expected 0", busy_cnt); end
    n_checks++;
    if (rd1 !== 64'd7) begin n_errors++; $display("FAIL flush_rd: got %h expected 7", rd1); end
    n_checks++;
    if (rbusy1 !== 1'b0 || rbusy2 !== 1'b0) begin n_errors++; $display("FAIL flush_rbusy: got %b/%b expected 0/0", rbusy1, rbusy2); end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] same_cycle;
    do_reset();
`ifdef REGFILE_BYPASS_EN
    same_cycle = 64'h1234;
`else
    same_cycle = 64'h0;
`endif
    ra1 = 9; we = 1; wa = 9; wd = 64'h1234;
    #1;
    n_checks++;
    if (rd1 !== same_cycle) begin n_errors++; $display("FAIL byp_same: got %h expected %h", rd1, same_cycle); end
    step();
    idle();
    #1;
    n_checks++;
    if (rd1 !== 64'h1234) begin n_errors++; $display("FAIL byp_next: got %h expected 1234", rd1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    we = 1; wa = 4; wd = 64'hA5A5_A5A5_0000_1111; alloc_en = 1; alloc_addr = 6;
    step();
    idle();
    n_checks++;
    if (busy_cnt !== 6'd1) begin n_errors++; $display("FAIL arst_pre_cnt: got %0d expected 1", busy_cnt); end
    ra1 = 4; ra2 = 6;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy_cnt !== '0) begin n_errors++; $display("FAIL arst_cnt: got %0d expected 0", busy_cnt); end
    rst = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (rd1 !== '0) begin n_errors++; $display("FAIL arst_data: got %h expected 0", rd1); end
    n_checks++;
    if (rbusy2 !== 1'b0) begin n_errors++; $display("FAIL arst_busy: got %b expected 0", rbusy2); end
    alloc_en = 1; alloc_addr = 6;
    #1;
    n_checks++;
    if (alloc_ok !== 1'b1) begin n_errors++; $display("FAIL arst_realloc: got %b expected 1", alloc_ok); end
    step();
    idle();
  endtask

  task automatic test_random();
    logic [XLEN-1:0] e_rd;
    logic            e_b;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ra1        = AW'($urandom_range(0, NREG-1));
      ra2        = ($urandom_range(0, 3) == 0) ? ra1 : AW'($urandom_range(0, NREG-1));
      we         = 1'($urandom_range(0, 1));
      wa         = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG-1));
      wd         = {$urandom, $urandom};
      alloc_en   = 1'($urandom_range(0, 1));
      alloc_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG-1));
      flush      = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) ra1 = wa;
      #1;
      e_rd = exp_rd(ra1);
      n_checks++;
      if (rd1 !== e_rd) begin n_errors++; $display("FAIL rnd_rd1 cyc %0d: got %h expected %h", c, rd1, e_rd); end
      e_rd = exp_rd(ra2);
      n_checks++;
      if (rd2 !== e_rd) begin n_errors++; $display("FAIL rnd_rd2 cyc %0d: got %h expected %h", c, rd2, e_rd); end
      e_b = exp_rbusy(ra1);
      n_checks++;
      if (rbusy1 !== e_b) begin n_errors++; $display("FAIL rnd_rbusy1 cyc %0d: got %b expected %b", c, rbusy1, e_b); end
      e_b = exp_rbusy(ra2);
      n_checks++;
      if (rbusy2 !== e_b) begin n_errors++; $display("FAIL rnd_rbusy2 cyc %0d: got %b expected %b", c, rbusy2, e_b); end
      e_b = exp_alloc_ok();
      n_checks++;
      if (alloc_ok !== e_b) begin n_errors++; $display("FAIL rnd_alloc_ok cyc %0d: got %b expected %b", c, alloc_ok, e_b); end
      step();
      n_checks++;
      if (int'(busy_cnt) != m_count()) begin n_errors++; $display("FAIL rnd_busy_cnt cyc %0d: got %0d expected %0d", c, busy_cnt, m_count()); end
    end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    ra1 = 0; ra2 = 0;
    idle();
    model_clear();
    test_reset();
    test_double_alloc();
    test_wb_alloc_same();
    test_x0();
    test_flush();
    test_bypass();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
